// File: rtl/seq_detect_param_if.sv
// Serial detector bus: sample/clear controls in, match pulses, counters and fill level out.
interface seq_detect_param_if #(
    parameter int N     = 3,
    parameter int CNT_W = 8
);
    localparam int FILL_W = $clog2(N + 1);

    logic              en;
    logic              s;
    logic              clr;
    logic              y1;
    logic              y2;
    logic [CNT_W-1:0]  cnt1;
    logic [CNT_W-1:0]  cnt2;
    logic [FILL_W-1:0] fill;

    modport master (output en, s, clr, input y1, y2, cnt1, cnt2, fill);
    modport slave  (input en, s, clr, output y1, y2, cnt1, cnt2, fill);
endinterface

// File: rtl/seq_detect_param.sv
// Parametrised dual-pattern serial detector with one-cycle match pulses,
// saturating match counters and a history-fill level.
module seq_detect_param #(
    parameter int           N       = 3,
    parameter logic [N-1:0] PAT_A   = 3'b011,
    parameter logic [N-1:0] PAT_B   = 3'b100,
    parameter bit           OVERLAP = 1'b1,
    parameter int           CNT_W   = 8
) (
    input logic ck,
    input logic rs,
    seq_detect_param_if.slave bus
);
    localparam int FILL_W = $clog2(N + 1);
    localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(N);
    localparam logic [CNT_W-1:0]  CNT_MAX  = '1;

    logic [N-1:0]      hist;
    logic [FILL_W-1:0] fill;
    logic              y1, y2;
    logic [CNT_W-1:0]  cnt1, cnt2;

    logic [N-1:0]      nh;
    logic [FILL_W-1:0] nf;
    logic              m_a, m_b;

    always_comb begin
        nh  = {hist[N-2:0], bus.s};
        nf  = (fill == FILL_MAX) ? fill : fill + 1'b1;
        m_a = (nf == FILL_MAX) && (nh == PAT_A);
        m_b = (nf == FILL_MAX) && (nh == PAT_B);
    end

    always_ff @(posedge ck) begin
        if (rs) begin
            hist <= '0;
            fill <= '0;
            y1   <= 1'b0;
            y2   <= 1'b0;
            cnt1 <= '0;
            cnt2 <= '0;
        end else begin
            y1 <= bus.en && m_a;
            y2 <= bus.en && m_b;
            if (bus.en) begin
                hist <= nh;
                // Non-overlap mode restarts collection so no bit is shared between matches.
                fill <= (!OVERLAP && (m_a || m_b)) ? '0 : nf;
            end
            // Clear wins over a same-edge increment.
            if (bus.clr) begin
                cnt1 <= '0;
                cnt2 <= '0;
            end else begin
                if (bus.en && m_a && cnt1 != CNT_MAX) cnt1 <= cnt1 + 1'b1;
                if (bus.en && m_b && cnt2 != CNT_MAX) cnt2 <= cnt2 + 1'b1;
            end
        end
    end

    assign bus.y1   = y1;
    assign bus.y2   = y2;
    assign bus.cnt1 = cnt1;
    assign bus.cnt2 = cnt2;
    assign bus.fill = fill;
endmodule

// File: tb/tb_seq_detect_param.sv
// Directed bench: overlap (a), non-overlap (b) and 2-bit-counter (c) detectors share one stimulus.
module tb_seq_detect_param;
    logic ck = 1'b0;
    logic rs = 1'b1;
    int   n_chk = 0;
    int   n_err = 0;

    always #5 ck = ~ck;

    seq_detect_param_if #(.N(3), .CNT_W(8)) ifa ();
    seq_detect_param_if #(.N(3), .CNT_W(8)) ifb ();
    seq_detect_param_if #(.N(3), .CNT_W(2)) ifc ();

    seq_detect_param #(.N(3), .PAT_A(3'b011), .PAT_B(3'b100), .OVERLAP(1'b1), .CNT_W(8))
        u_a (.ck(ck), .rs(rs), .bus(ifa));
    seq_detect_param #(.N(3), .PAT_A(3'b011), .PAT_B(3'b100), .OVERLAP(1'b0), .CNT_W(8))
        u_b (.ck(ck), .rs(rs), .bus(ifb));
    seq_detect_param #(.N(3), .PAT_A(3'b011), .PAT_B(3'b100), .OVERLAP(1'b1), .CNT_W(2))
        u_c (.ck(ck), .rs(rs), .bus(ifc));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Drive all three detectors, clock once, settle past the edge.
    task automatic step(input logic e, input logic d, input logic c = 1'b0);
        ifa.en = e; ifa.s = d; ifa.clr = c;
        ifb.en = e; ifb.s = d; ifb.clr = c;
        ifc.en = e; ifc.s = d; ifc.clr = c;
        @(posedge ck);
        #1;
    endtask

    task automatic do_reset();
        rs = 1'b1;
        step(1'b1, 1'b1);
        rs = 1'b0;
    endtask

    initial begin
        step(1'b0, 1'b0);
        // Reset with inputs toggling
        rs = 1'b1;
        step(1'b1, 1'b1);
        step(1'b0, 1'b0);
        chk("rst_y1", ifa.y1, 0);
        chk("rst_y2", ifa.y2, 0);
        chk("rst_cnt1", ifa.cnt1, 0);
        chk("rst_cnt2", ifa.cnt2, 0);
        chk("rst_fill", ifa.fill, 0);
        rs = 1'b0;

        // Stream 0,1,1,0,0,1,0,0
        step(1'b1, 1'b0);
        chk("b1_fill", ifa.fill, 1);
        chk("b1_y1", ifa.y1, 0);
        step(1'b1, 1'b1);
        chk("b2_fill", ifa.fill, 2);
        step(1'b1, 1'b1);
        chk("a_b3_y1", ifa.y1, 1);
        chk("a_b3_cnt1", ifa.cnt1, 1);
        chk("a_b3_fill", ifa.fill, 3);
        chk("b_b3_y1", ifb.y1, 1);
        chk("b_b3_fill", ifb.fill, 0);
        step(1'b1, 1'b0);
        chk("a_b4_y1", ifa.y1, 0);
        chk("a_b4_y2", ifa.y2, 0);
        step(1'b1, 1'b0);
        chk("a_b5_y2", ifa.y2, 1);
        chk("a_b5_cnt1", ifa.cnt1, 1);
        chk("a_b5_cnt2", ifa.cnt2, 1);
        chk("b_b5_y2", ifb.y2, 0);
        chk("b_b5_fill", ifb.fill, 2);
        step(1'b1, 1'b1);
        chk("a_b6_y2", ifa.y2, 0);
        chk("b_b6_fill", ifb.fill, 3);
        step(1'b1, 1'b0);
        step(1'b1, 1'b0);
        chk("b_b8_y2", ifb.y2, 1);
        chk("b_b8_cnt2", ifb.cnt2, 1);
        chk("b_b8_fill", ifb.fill, 0);
        chk("a_b8_y2", ifa.y2, 1);
        chk("a_b8_cnt2", ifa.cnt2, 2);

        // Enable gaps
        do_reset();
        step(1'b1, 1'b0);
        step(1'b0, 1'b1);
        chk("gap_y1_a", ifa.y1, 0);
        chk("gap_fill_a", ifa.fill, 1);
        step(1'b0, 1'b1);
        chk("gap_y1_b", ifa.y1, 0);
        step(1'b1, 1'b1);
        chk("gap_fill_c", ifa.fill, 2);
        step(1'b1, 1'b1);
        chk("gap_y1_hit", ifa.y1, 1);
        chk("gap_cnt1", ifa.cnt1, 1);
        step(1'b0, 1'b1);
        chk("gap_y1_off", ifa.y1, 0);
        chk("gap_hold_fill", ifa.fill, 3);

        // Counter saturation on the 2-bit counter
        do_reset();
        for (int k = 1; k <= 5; k++) begin
            step(1'b1, 1'b0);
            chk("sat_y1_lo", ifc.y1, 0);
            step(1'b1, 1'b1);
            step(1'b1, 1'b1);
            chk("sat_y1", ifc.y1, 1);
            chk("sat_cnt1", ifc.cnt1, (k > 3) ? 3 : k);
        end
        chk("sat_a_cnt1", ifa.cnt1, 5);
        chk("sat_b_cnt1", ifb.cnt1, 5);

        // Mid-stream reset discards partial bits
        do_reset();
        step(1'b1, 1'b0);
        step(1'b1, 1'b1);
        rs = 1'b1;
        step(1'b1, 1'b1, 1'b0);
        rs = 1'b0;
        chk("mrst_fill0", ifa.fill, 0);
        step(1'b1, 1'b1);
        chk("mrst_y1", ifa.y1, 0);
        chk("mrst_fill", ifa.fill, 1);

        // Clear on the completing edge
        do_reset();
        step(1'b1, 1'b0);
        step(1'b1, 1'b1);
        step(1'b1, 1'b1);
        chk("clr_pre_cnt1", ifa.cnt1, 1);
        step(1'b1, 1'b0);
        step(1'b1, 1'b1);
        step(1'b1, 1'b1, 1'b1);
        chk("clr_y1", ifa.y1, 1);
        chk("clr_cnt1", ifa.cnt1, 0);
        chk("clr_fill", ifa.fill, 3);
        step(1'b0, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
